// File: rtl/lgn_frame_loader_if.sv
// Signal bundle of the lgn frame loader: host pad inputs, lgn byte stream and the SRAM macro port.
// The loader connects through 'master'; the pads, lgn and SRAM side connect through 'slave'.
interface lgn_frame_loader_if;
  logic       host_strobe;
  logic [7:0] host_data;
  logic       lgn_ready;
  logic       lgn_we;
  logic [7:0] lgn_data;
  logic       frame_done;
  logic       overflow;
  logic       sram_cen;
  logic       sram_gwen;
  logic [7:0] sram_wen;
  logic [8:0] sram_a;
  logic [7:0] sram_d;
  logic [7:0] sram_q;

  modport master (
    input  host_strobe, host_data, lgn_ready, sram_q,
    output lgn_we, lgn_data, frame_done, overflow,
           sram_cen, sram_gwen, sram_wen, sram_a, sram_d
  );

  modport slave (
    output host_strobe, host_data, lgn_ready, sram_q,
    input  lgn_we, lgn_data, frame_done, overflow,
           sram_cen, sram_gwen, sram_wen, sram_a, sram_d
  );
endinterface

// File: rtl/lgn_frame_loader.sv
// Collects strobed host bytes into ping-pong frame banks of a single-port 512x8 SRAM and
// replays each complete frame to lgn as a byte stream with ready backpressure.
module lgn_frame_loader #(
  parameter int FRAME_BYTES = 98,
  parameter int SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                rst_n,
  lgn_frame_loader_if.master bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [7:0] LAST_IDX = 8'(FRAME_BYTES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic                   wr_bank_q, wr_bank_d;
  logic [7:0]             wr_idx_q, wr_idx_d;
  logic [1:0]             full_q, full_d;
  logic                   overflow_q, overflow_d;
  logic [1:0]             state_q, state_d;
  logic                   rd_bank_q, rd_bank_d;
  logic [7:0]             rd_idx_q, rd_idx_d;
  logic [7:0]             data_q, data_d;
  logic                   capt_q, capt_d;

  logic wr_pulse;
  logic wr_go;
  logic wr_last;
  logic rd_go;

  // Writer: synchronise the pad strobe, detect its rising edge and fill the current bank.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], bus.host_strobe};
    edge_d     = sync_q[SYNC_STAGES-1];
    wr_pulse   = sync_q[SYNC_STAGES-1] & ~edge_q;
    wr_go      = wr_pulse & ~full_q[wr_bank_q];
    wr_last    = wr_go & (wr_idx_q == LAST_IDX);
    wr_idx_d   = wr_idx_q;
    wr_bank_d  = wr_bank_q;
    overflow_d = overflow_q | (wr_pulse & full_q[wr_bank_q]);
    if (wr_last) begin
      wr_idx_d  = '0;
      wr_bank_d = ~wr_bank_q;
    end else if (wr_go) begin
      wr_idx_d = wr_idx_q + 8'd1;
    end
  end

  // A bank is never freed and filled in the same cycle, so both updates can apply.
  always_comb begin
    full_d = full_q;
    if (state_q == ST_DONE) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (wr_last) begin
      full_d[wr_bank_q] = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    rd_idx_d  = rd_idx_q;
    data_d    = data_q;
    capt_d    = capt_q;
    rd_go     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!wr_go) begin
          rd_go   = 1'b1;
          capt_d  = 1'b0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // The SRAM output is only trusted in the first HOLD cycle; later cycles replay the capture.
        if (!capt_q) begin
          data_d = bus.sram_q;
          capt_d = 1'b1;
        end
        if (bus.lgn_ready) begin
          capt_d = 1'b0;
          if (rd_idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            rd_idx_d = rd_idx_q + 8'd1;
            state_d  = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        rd_bank_d = ~rd_bank_q;
        rd_idx_d  = '0;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.sram_cen  = 1'b1;
    bus.sram_gwen = 1'b1;
    bus.sram_wen  = 8'hFF;
    bus.sram_a    = '0;
    bus.sram_d    = '0;
    if (wr_go) begin
      bus.sram_cen  = 1'b0;
      bus.sram_gwen = 1'b0;
      bus.sram_wen  = 8'h00;
      bus.sram_a    = {wr_bank_q, wr_idx_q};
      bus.sram_d    = bus.host_data;
    end else if (rd_go) begin
      bus.sram_cen = 1'b0;
      bus.sram_a   = {rd_bank_q, rd_idx_q};
    end
  end

  assign bus.lgn_we     = (state_q == ST_HOLD);
  assign bus.lgn_data   = (state_q == ST_HOLD && !capt_q) ? bus.sram_q : data_q;
  assign bus.frame_done = (state_q == ST_DONE);
  assign bus.overflow   = overflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      edge_q     <= 1'b0;
      wr_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      full_q     <= '0;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
      rd_bank_q  <= 1'b0;
      rd_idx_q   <= '0;
      data_q     <= '0;
      capt_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      edge_q     <= edge_d;
      wr_bank_q  <= wr_bank_d;
      wr_idx_q   <= wr_idx_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      rd_bank_q  <= rd_bank_d;
      rd_idx_q   <= rd_idx_d;
      data_q     <= data_d;
      capt_q     <= capt_d;
    end
  end

endmodule
